parking_sensor_ctrl: RTL and testbench
======================================

PARKING_SENSOR_CTRL -- requirements
Module: parking_sensor_ctrl

Interface
REQ-001 SHALL have parameter N_SENSORS, default 32: number of parking-bay sensor inputs (1..32).
REQ-002 SHALL have parameter DATA_W, default 32: native-bus data width.
REQ-003 SHALL have parameter PRESC_RST, default 1000: reset value of the PRESCALE register.
REQ-004 SHALL have port clk, input, 1: single clock; all state is on its rising edge.
REQ-005 SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-006 SHALL have port sensor_in, input, N_SENSORS: raw asynchronous bay sensors; 1 means occupied.
REQ-007 SHALL have port valid, input, 1: native-bus request strobe.
REQ-008 SHALL have port address, input, 3: word register index.
REQ-009 SHALL have port wdata, input, DATA_W: write data.
REQ-010 SHALL have port wstrb, input, 4: byte write strobes; all zero means read.
REQ-011 SHALL have port rdata, output, DATA_W: registered read data.
REQ-012 SHALL have port ready, output, 1: one-cycle acknowledge.
REQ-013 SHALL have port irq, output, 1: level interrupt, OR of (EVENT & IRQ_EN).

Function
REQ-014 Each sensor_in bit SHALL pass a 2-flop synchronizer before any use.
REQ-015 Prescaler: counts 0..PRESCALE-1; tick pulses 1 cycle at wrap; PRESCALE=0 behaves as 1 (tick every cycle); a PRESCALE write restarts the count at 0.
REQ-016 On each tick, the synchronized vector SHALL shift into a 3-deep sample history.
REQ-017 FSM states: DISABLED, WARMUP, RUN; DISABLED→WARMUP on CTRL.en=1; WARMUP→RUN after 3 ticks; any state→DISABLED on CTRL.en=0.
REQ-018 In DISABLED, the prescaler and history SHALL be held cleared; STATE, COUNT and EVENT SHALL retain their values.
REQ-019 At the third WARMUP tick, STATE SHALL load the sample if all 3 samples agree per bit; no events SHALL be raised.
REQ-020 In RUN, on a tick, each bit whose 3 samples agree and differ from STATE SHALL update STATE; a 0→1 bit SHALL set EVENT.rise[i]; a 1→0 bit SHALL set EVENT.fall[i] (fall occupies bits 31:16 only when N_SENSORS≤16, otherwise it is a separate register).
REQ-021 Register map: 0 CTRL (bit0 en, RW); 1 PRESCALE (15:0, RW); 2 STATE (RO); 3 COUNT (RO, popcount of STATE); 4 RISE (W1C); 5 FALL (W1C); 6 IRQ_EN (RW, bit i enables RISE[i]|FALL[i]); 7 reads 0.
REQ-022 COUNT SHALL be registered and valid one cycle after a STATE change; width 6 bits, zero-extended.
REQ-023 Bus: valid→ready=1 on the next cycle for exactly one cycle, with rdata valid in that cycle; back-to-back valid SHALL be accepted every cycle.
REQ-024 Writes honour wstrb per byte; writes to RO or unmapped addresses are ignored and still acknowledged.
REQ-025 If a W1C clear and an event set hit the same bit in the same cycle, the set SHALL win.
REQ-026 Bits at or above N_SENSORS SHALL read 0 and SHALL never set.
REQ-027 irq SHALL be registered, asserting one cycle after the enabling EVENT bit sets.
REQ-028 Latency from a sensor_in edge to the STATE update is 2 cycles plus 3 to 4 ticks.

Reset
REQ-029 On reset assertion: CTRL=0, PRESCALE=PRESC_RST, STATE=0, COUNT=0, RISE=FALL=0, IRQ_EN=0, FSM=DISABLED, ready=0, rdata=0, irq=0, synchronizers and history=0.
REQ-030 Reset mid-transaction SHALL drop any pending ready; the first valid after release SHALL be serviced normally.

Structure
REQ-031 Register addresses, field widths and FSM state encodings SHALL live in the shared package/header parking_sensor_ctrl.vh.
REQ-032 The per-bit synchronizer SHALL be the sub-module iob_sync, instantiated with width N_SENSORS.

Verification
REQ-033 Reset then read regs 0..7 -> 0, 1000, 0, 0, 0, 0, 0, 0.
REQ-034 PRESCALE=0, en=1, sensor_in=0x5 -> after WARMUP, STATE=0x5, COUNT=2, RISE=0.
REQ-035 RUN, PRESCALE=4, IRQ_EN=0x2, sensor_in bit1 0→1 -> within 2+16 cycles STATE[1]=1, RISE=0x2, irq=1; write RISE=0x2 -> irq=0.
REQ-036 A 1-tick glitch on bit3 -> STATE, RISE and FALL unchanged.
REQ-037 W1C of RISE[0] in the same cycle bit0 sets again -> RISE[0]=1 after the write.
REQ-038 en=0 during WARMUP, then en=1 -> full 3-tick WARMUP repeats with no events; async rst pulse mid-read -> ready never asserts for that read.

Source files
------------

// File: rtl/parking_sensor_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : parking_sensor_ctrl_pkg
// Description : Shared register map, field widths, FSM encoding and helpers
//               for the parking-bay sensor controller.
// Revision    : 1.0 - initial release
// ============================================================================
package parking_sensor_ctrl_pkg;

    // Word register indices on the native bus
    localparam logic [2:0] ADDR_CTRL  = 3'd0;
    localparam logic [2:0] ADDR_PRESC = 3'd1;
    localparam logic [2:0] ADDR_STATE = 3'd2;
    localparam logic [2:0] ADDR_COUNT = 3'd3;
    localparam logic [2:0] ADDR_RISE  = 3'd4;
    localparam logic [2:0] ADDR_FALL  = 3'd5;
    localparam logic [2:0] ADDR_IRQEN = 3'd6;
    localparam logic [2:0] ADDR_RSVD  = 3'd7;

    // Field widths
    localparam int PRESC_W = 16;
    localparam int COUNT_W = 6;

    // Number of ticks spent filling the history before STATE is trusted
    localparam logic [1:0] WARMUP_TICKS = 2'd3;

    // Controller operating states
    typedef enum logic [1:0] {
        ST_DISABLED = 2'd0,
        ST_WARMUP   = 2'd1,
        ST_RUN      = 2'd2
    } fsm_state_e;

    // Number of set bits in a 32-bit word (0..32 fits in COUNT_W bits)
    function automatic logic [COUNT_W-1:0] f_popcount(input logic [31:0] v);
        logic [COUNT_W-1:0] n;
        n = '0;
        for (int i = 0; i < 32; i++) begin
            n = n + {{(COUNT_W-1){1'b0}}, v[i]};
        end
        return n;
    endfunction

endpackage : parking_sensor_ctrl_pkg
`default_nettype wire

// File: rtl/iob_sync.sv
`default_nettype none
// ============================================================================
// Module      : iob_sync
// Description : Per-bit two-flop synchronizer for asynchronous inputs.
// Revision    : 1.0 - initial release
// ============================================================================
module iob_sync #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] i_async,
    output logic [WIDTH-1:0] o_sync
);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;

    // Two back-to-back flops give metastability a full cycle to resolve
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_meta <= '0;
            r_sync <= '0;
        end else begin
            r_meta <= i_async;
            r_sync <= r_meta;
        end
    end

    assign o_sync = r_sync;

endmodule : iob_sync
`default_nettype wire

// File: rtl/parking_sensor_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : parking_sensor_ctrl
// Description : Parking-bay sensor debouncer with prescaled sampling, 3-deep
//               majority-free (unanimous) filtering, occupancy count, rise/
//               fall event latches and a native-bus register interface.
// Revision    : 1.0 - initial release
// ============================================================================
module parking_sensor_ctrl
    import parking_sensor_ctrl_pkg::*;
#(
    parameter int N_SENSORS = 32,
    parameter int DATA_W    = 32,
    parameter int PRESC_RST = 1000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_SENSORS-1:0] sensor_in,
    input  logic                 valid,
    input  logic [2:0]           address,
    input  logic [DATA_W-1:0]    wdata,
    input  logic [3:0]           wstrb,
    output logic [DATA_W-1:0]    rdata,
    output logic                 ready,
    output logic                 irq
);

    // ------------------------------------------------------------------
    // Declarations
    // ------------------------------------------------------------------
    logic [N_SENSORS-1:0] w_sync;

    logic                 r_en;
    logic [PRESC_W-1:0]   r_presc;
    logic [PRESC_W-1:0]   r_cnt;
    logic [N_SENSORS-1:0] r_state;
    logic [COUNT_W-1:0]   r_count;
    logic [N_SENSORS-1:0] r_rise;
    logic [N_SENSORS-1:0] r_fall;
    logic [N_SENSORS-1:0] r_irq_en;
    logic [N_SENSORS-1:0] r_hist0;
    logic [N_SENSORS-1:0] r_hist1;
    logic [N_SENSORS-1:0] r_hist2;
    logic                 r_eval;
    logic [1:0]           r_wtick;
    fsm_state_e           r_fsm;
    fsm_state_e           w_fsm_nxt;
    logic                 r_ready;
    logic                 r_irq;
    logic [DATA_W-1:0]    r_rdata;

    logic [31:0]          w_wdata32;
    logic [31:0]          w_bmask;
    logic [31:0]          w_wbits;
    logic                 w_wr;
    logic                 w_wr_presc;
    logic                 w_run_en;
    logic [PRESC_W-1:0]   w_presc_m1;
    logic                 w_tick;
    logic                 w_eval;
    logic                 w_warm_load;
    logic                 w_run_upd;
    logic [N_SENSORS-1:0] w_agree;
    logic [N_SENSORS-1:0] w_samp;
    logic [N_SENSORS-1:0] w_chg;
    logic [N_SENSORS-1:0] w_rise_set;
    logic [N_SENSORS-1:0] w_fall_set;
    logic [N_SENSORS-1:0] w_rise_clr;
    logic [N_SENSORS-1:0] w_fall_clr;
    logic [N_SENSORS-1:0] w_fall_clr_pk;
    logic [31:0]          w_rise_word;
    logic [31:0]          w_rd_word;

    // ------------------------------------------------------------------
    // Input synchronization
    // ------------------------------------------------------------------
    iob_sync #(
        .WIDTH   (N_SENSORS)
    ) u_sync (
        .clk     (clk),
        .rst     (rst),
        .i_async (sensor_in),
        .o_sync  (w_sync)
    );

    // ------------------------------------------------------------------
    // Bus write decode: byte strobes expand into a bit mask
    // ------------------------------------------------------------------
    assign w_wdata32  = 32'(wdata);
    assign w_bmask    = {{8{wstrb[3]}}, {8{wstrb[2]}}, {8{wstrb[1]}}, {8{wstrb[0]}}};
    assign w_wbits    = w_wdata32 & w_bmask;
    assign w_wr       = valid && (wstrb != 4'b0000);
    assign w_wr_presc = w_wr && (address == ADDR_PRESC);

    assign w_rise_clr = (w_wr && (address == ADDR_RISE)) ? w_wbits[N_SENSORS-1:0] : '0;
    assign w_fall_clr = ((w_wr && (address == ADDR_FALL)) ? w_wbits[N_SENSORS-1:0] : '0)
                      | w_fall_clr_pk;

    // Narrow configurations pack FALL into the upper half of the RISE word
    generate
        if (N_SENSORS <= 16) begin : g_packed
            assign w_rise_word   = {16'(r_fall), 16'(r_rise)};
            assign w_fall_clr_pk = (w_wr && (address == ADDR_RISE)) ?
                                   w_wbits[16 +: N_SENSORS] : '0;
        end else begin : g_split
            assign w_rise_word   = 32'(r_rise);
            assign w_fall_clr_pk = '0;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Prescaler and sample history
    // ------------------------------------------------------------------
    assign w_run_en   = r_en && (r_fsm != ST_DISABLED);
    assign w_presc_m1 = (r_presc == '0) ? '0 : (r_presc - 16'd1);
    assign w_tick     = w_run_en && (r_cnt >= w_presc_m1);
    assign w_eval     = r_eval && w_run_en;

    // Free-running divider; held at zero while disabled or on reprogramming
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (!w_run_en || w_wr_presc || w_tick) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 16'd1;
        end
    end

    // Shift the synchronized vector into history on each tick; evaluate next cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hist0 <= '0;
            r_hist1 <= '0;
            r_hist2 <= '0;
            r_eval  <= 1'b0;
        end else if (!w_run_en) begin
            r_hist0 <= '0;
            r_hist1 <= '0;
            r_hist2 <= '0;
            r_eval  <= 1'b0;
        end else begin
            r_eval <= w_tick;
            if (w_tick) begin
                r_hist0 <= w_sync;
                r_hist1 <= r_hist0;
                r_hist2 <= r_hist1;
            end
        end
    end

    // Count warm-up ticks; cleared whenever warm-up is not in progress
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wtick <= 2'd0;
        end else if (r_fsm != ST_WARMUP) begin
            r_wtick <= 2'd0;
        end else if (w_tick && (r_wtick != WARMUP_TICKS)) begin
            r_wtick <= r_wtick + 2'd1;
        end
    end

    // ------------------------------------------------------------------
    // Operating-state FSM
    // ------------------------------------------------------------------
    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fsm <= ST_DISABLED;
        end else begin
            r_fsm <= w_fsm_nxt;
        end
    end

    // Next state plus the STATE load/update strobes
    always_comb begin
        w_fsm_nxt   = r_fsm;
        w_warm_load = 1'b0;
        w_run_upd   = 1'b0;
        case (r_fsm)
            ST_DISABLED: begin
                if (r_en) w_fsm_nxt = ST_WARMUP;
            end
            ST_WARMUP: begin
                if (!r_en) begin
                    w_fsm_nxt = ST_DISABLED;
                end else if (w_eval && (r_wtick == WARMUP_TICKS)) begin
                    w_warm_load = 1'b1;
                    w_fsm_nxt   = ST_RUN;
                end
            end
            ST_RUN: begin
                if (!r_en) begin
                    w_fsm_nxt = ST_DISABLED;
                end else begin
                    w_run_upd = w_eval;
                end
            end
            default: w_fsm_nxt = ST_DISABLED;
        endcase
    end

    // ------------------------------------------------------------------
    // Filtered state and events
    // ------------------------------------------------------------------
    assign w_samp     = r_hist0;
    assign w_agree    = (r_hist0 & r_hist1 & r_hist2) | ~(r_hist0 | r_hist1 | r_hist2);
    assign w_chg      = w_agree & (w_samp ^ r_state);
    assign w_rise_set = w_run_upd ? (w_chg &  w_samp) : '0;
    assign w_fall_set = w_run_upd ? (w_chg & ~w_samp) : '0;

    // STATE takes every unanimous bit: silently at warm-up end, with events in RUN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= '0;
        end else if (w_warm_load) begin
            r_state <= (r_state & ~w_agree) | (w_samp & w_agree);
        end else if (w_run_upd) begin
            r_state <= r_state ^ w_chg;
        end
    end

    // Occupancy count trails STATE by one cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else begin
            r_count <= f_popcount(32'(r_state));
        end
    end

    // Event latches: a new event overrides a simultaneous write-one-to-clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rise <= '0;
            r_fall <= '0;
        end else begin
            r_rise <= (r_rise & ~w_rise_clr) | w_rise_set;
            r_fall <= (r_fall & ~w_fall_clr) | w_fall_set;
        end
    end

    // Interrupt is a registered OR of enabled pending events
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_irq <= 1'b0;
        end else begin
            r_irq <= |((r_rise | r_fall) & r_irq_en);
        end
    end

    // ------------------------------------------------------------------
    // Register file and bus response
    // ------------------------------------------------------------------
    // Read-write configuration registers with per-byte strobes
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_en     <= 1'b0;
            r_presc  <= PRESC_W'(PRESC_RST);
            r_irq_en <= '0;
        end else if (w_wr) begin
            if (address == ADDR_CTRL) begin
                r_en <= (r_en & ~w_bmask[0]) | w_wbits[0];
            end
            if (address == ADDR_PRESC) begin
                r_presc <= (r_presc & ~w_bmask[PRESC_W-1:0]) | w_wbits[PRESC_W-1:0];
            end
            if (address == ADDR_IRQEN) begin
                r_irq_en <= (r_irq_en & ~w_bmask[N_SENSORS-1:0]) | w_wbits[N_SENSORS-1:0];
            end
        end
    end

    // Read multiplexer; unimplemented bits read as zero
    always_comb begin
        w_rd_word = 32'd0;
        case (address)
            ADDR_CTRL:  w_rd_word = {31'd0, r_en};
            ADDR_PRESC: w_rd_word = {16'd0, r_presc};
            ADDR_STATE: w_rd_word = 32'(r_state);
            ADDR_COUNT: w_rd_word = {26'd0, r_count};
            ADDR_RISE:  w_rd_word = w_rise_word;
            ADDR_FALL:  w_rd_word = 32'(r_fall);
            ADDR_IRQEN: w_rd_word = 32'(r_irq_en);
            ADDR_RSVD:  w_rd_word = 32'd0;
            default:    w_rd_word = 32'd0;
        endcase
    end

    // Single-cycle acknowledge with registered read data
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ready <= 1'b0;
            r_rdata <= '0;
        end else begin
            r_ready <= valid;
            if (valid) begin
                r_rdata <= DATA_W'(w_rd_word);
            end
        end
    end

    assign rdata = r_rdata;
    assign ready = r_ready;
    assign irq   = r_irq;

endmodule : parking_sensor_ctrl
`default_nettype wire

// File: tb/tb_parking_sensor_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_parking_sensor_ctrl
// Description : Directed self-checking bench for parking_sensor_ctrl with a
//               read-data scoreboard queue.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_parking_sensor_ctrl;

    localparam logic [2:0] A_CTRL  = 3'd0;
    localparam logic [2:0] A_PRESC = 3'd1;
    localparam logic [2:0] A_STATE = 3'd2;
    localparam logic [2:0] A_COUNT = 3'd3;
    localparam logic [2:0] A_RISE  = 3'd4;
    localparam logic [2:0] A_FALL  = 3'd5;
    localparam logic [2:0] A_IRQEN = 3'd6;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] sensor_in;
    logic        valid;
    logic [2:0]  address;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [31:0] rdata;
    logic        ready;
    logic        irq;

    int n_err = 0;
    int n_chk = 0;

    logic [31:0] q_exp[$];
    string       q_tag[$];

    always #5 clk = ~clk;

    parking_sensor_ctrl #(
        .N_SENSORS (32),
        .DATA_W    (32),
        .PRESC_RST (1000)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .sensor_in (sensor_in),
        .valid     (valid),
        .address   (address),
        .wdata     (wdata),
        .wstrb     (wstrb),
        .rdata     (rdata),
        .ready     (ready),
        .irq       (irq)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // One bus transaction, started just after a falling edge
    task automatic bus(input logic [2:0] a, input logic [31:0] d, input logic [3:0] s,
                       input bit push, input logic [31:0] exp, input string tag);
        logic [31:0] e;
        string       t;
        valid   = 1'b1;
        address = a;
        wdata   = d;
        wstrb   = s;
        if (push) begin
            q_exp.push_back(exp);
            q_tag.push_back(tag);
        end
        @(negedge clk);
        valid = 1'b0;
        wstrb = 4'h0;
        chk({tag, "_ready"}, {31'd0, ready}, 32'd1);
        if (q_exp.size() > 0) begin
            e = q_exp.pop_front();
            t = q_tag.pop_front();
            if (ready === 1'b1) chk(t, rdata, e);
        end
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        bus(a, d, 4'hF, 1'b0, 32'd0, "wr");
    endtask

    task automatic rd(input logic [2:0] a, input logic [31:0] exp, input string tag);
        bus(a, 32'd0, 4'h0, 1'b1, exp, tag);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Back-to-back reads until the expected value appears or the budget expires
    task automatic poll(input logic [2:0] a, input logic [31:0] exp, input int budget,
                        input string tag);
        int          k;
        logic [31:0] v;
        k = 0;
        v = 32'hx;
        while (k < budget && v !== exp) begin
            valid   = 1'b1;
            address = a;
            wstrb   = 4'h0;
            @(negedge clk);
            valid = 1'b0;
            v = rdata;
            k++;
        end
        chk(tag, v, exp);
    endtask

    initial begin
        rst       = 1'b1;
        sensor_in = 32'd0;
        valid     = 1'b0;
        address   = 3'd0;
        wdata     = 32'd0;
        wstrb     = 4'h0;
        repeat (3) @(negedge clk);
        chk("rst_ready", {31'd0, ready}, 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_irq",   {31'd0, irq},   32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Register reset values
        rd(3'd0, 32'd0,    "r0");
        rd(3'd1, 32'd1000, "r1");
        rd(3'd2, 32'd0,    "r2");
        rd(3'd3, 32'd0,    "r3");
        rd(3'd4, 32'd0,    "r4");
        rd(3'd5, 32'd0,    "r5");
        rd(3'd6, 32'd0,    "r6");
        rd(3'd7, 32'd0,    "r7");

        // Warm-up with tick every cycle loads STATE without events
        sensor_in = 32'h5;
        wr(A_PRESC, 32'd0);
        wr(A_CTRL, 32'd1);
        idle(10);
        rd(A_STATE, 32'h5, "warm_state");
        rd(A_COUNT, 32'd2, "warm_count");
        rd(A_RISE,  32'd0, "warm_rise");
        rd(A_FALL,  32'd0, "warm_fall");
        chk("warm_irq", {31'd0, irq}, 32'd0);

        // Rising edge on bit1 with interrupt enabled
        wr(A_PRESC, 32'd4);
        wr(A_IRQEN, 32'h2);
        sensor_in = 32'h7;
        poll(A_STATE, 32'h7, 18, "rise_latency");
        chk("rise_irq", {31'd0, irq}, 32'd1);
        rd(A_RISE,  32'h2, "rise_rise");
        rd(A_FALL,  32'h0, "rise_fall");
        rd(A_COUNT, 32'd3, "rise_count");
        wr(A_RISE, 32'h2);
        chk("irq_hold", {31'd0, irq}, 32'd1);
        idle(1);
        chk("irq_clr", {31'd0, irq}, 32'd0);
        rd(A_RISE, 32'h0, "w1c_rise");

        // One-tick glitch on bit3 is filtered out
        sensor_in = 32'hF;
        idle(4);
        sensor_in = 32'h7;
        idle(24);
        rd(A_STATE, 32'h7, "glitch_state");
        rd(A_RISE,  32'h0, "glitch_rise");
        rd(A_FALL,  32'h0, "glitch_fall");

        // Bit0 falls, then a W1C of RISE[0] collides with its new rising event
        wr(A_PRESC, 32'd0);
        sensor_in = 32'h6;
        poll(A_STATE, 32'h6, 40, "fall_state");
        rd(A_FALL, 32'h1, "fall_fall");
        rd(A_RISE, 32'h0, "fall_rise");
        sensor_in = 32'h7;
        idle(5);
        wr(A_RISE, 32'h1);
        rd(A_RISE,  32'h1, "setwins_rise");
        rd(A_STATE, 32'h7, "setwins_state");

        // Aborted warm-up restarts from scratch after re-enable
        wr(A_RISE, 32'hFFFF_FFFF);
        wr(A_FALL, 32'hFFFF_FFFF);
        wr(A_CTRL, 32'd0);
        wr(A_PRESC, 32'd4);
        sensor_in = 32'h0;
        idle(4);
        wr(A_CTRL, 32'd1);
        idle(10);
        wr(A_CTRL, 32'd0);
        wr(A_CTRL, 32'd1);
        idle(8);
        rd(A_STATE, 32'h7, "rewarm_hold");
        idle(20);
        rd(A_STATE, 32'h0, "rewarm_state");
        rd(A_COUNT, 32'd0, "rewarm_count");
        rd(A_RISE,  32'h0, "rewarm_rise");
        rd(A_FALL,  32'h0, "rewarm_fall");

        // Asynchronous reset during a read drops its acknowledge
        valid   = 1'b1;
        address = A_PRESC;
        wstrb   = 4'h0;
        #2 rst  = 1'b1;
        @(posedge clk);
        #2 rst  = 1'b0;
        @(negedge clk);
        valid = 1'b0;
        chk("rstmid_ready", {31'd0, ready}, 32'd0);
        rd(A_PRESC, 32'd1000, "post_rst_presc");
        rd(A_CTRL,  32'd0,    "post_rst_ctrl");
        rd(A_STATE, 32'd0,    "post_rst_state");

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    // Absolute time guard so the run always ends
    initial begin
        #200000;
        $display("FAIL timeout: observed running expected finished");
        $fatal(1, "timeout");
    end

endmodule : tb_parking_sensor_ctrl
`default_nettype wire
